coin_tracker: RTL and testbench

COIN_TRACKER -- requirements
Module: coin_tracker

---
 rtl/coin_tracker_pkg.sv | 20 ++
 rtl/coin_tracker_bcd_sat_counter.sv | 64 ++++++
 rtl/coin_tracker.sv | 138 +++++++++++++
 tb/tb_coin_tracker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/coin_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coin_tracker_pkg
// Description : Shared constants for the coin tracker: one-hot FSM state
//               encoding and default configuration values.
// Revision    : 1.0 - initial release
// ============================================================================
package coin_tracker_pkg;

   // One-hot state encoding; bit positions map directly onto the
   // q_Idle / q_Run / q_Done output flags.
   localparam logic [2:0] ST_IDLE = 3'b001;
   localparam logic [2:0] ST_RUN  = 3'b010;
   localparam logic [2:0] ST_DONE = 3'b100;

   localparam int unsigned NUM_COINS_DEF = 5;
   localparam int unsigned CNT_MAX_DEF   = 99;

endpackage : coin_tracker_pkg
`default_nettype wire

// File: rtl/coin_tracker_bcd_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_sat_counter
// Description : Two-digit BCD incrementer that saturates at CNT_MAX.
//               Synchronous clear has priority over the increment enable.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset (count -> 00)
//               i_clr   - synchronous clear of the count
//               i_en    - increment by one (ignored at saturation)
//               o_ones  - BCD ones digit
//               o_tens  - BCD tens digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_sat_counter #(
   parameter int unsigned CNT_MAX = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clr,
   input  logic       i_en,
   output logic [3:0] o_ones,
   output logic [3:0] o_tens
);

   localparam logic [3:0] C_MAX_ONES = 4'(CNT_MAX % 10);
   localparam logic [3:0] C_MAX_TENS = 4'(CNT_MAX / 10);

   logic [3:0] ones_q, ones_d;
   logic [3:0] tens_q, tens_d;
   logic       at_max;

   assign at_max = (tens_q == C_MAX_TENS) && (ones_q == C_MAX_ONES);

   always_comb begin
      ones_d = ones_q;
      tens_d = tens_q;
      if (i_clr) begin
         ones_d = 4'd0;
         tens_d = 4'd0;
      end else if (i_en && !at_max) begin
         if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ones_q <= 4'd0;
         tens_q <= 4'd0;
      end else begin
         ones_q <= ones_d;
         tens_q <= tens_d;
      end
   end

   assign o_ones = ones_q;
   assign o_tens = tens_q;

endmodule : bcd_sat_counter
`default_nettype wire

// File: rtl/coin_tracker.sv
`default_nettype none
// ============================================================================
// Module      : coin_tracker
// Description : Tracks on-screen coin slot visibility and the collected-coin
//               count for one run (IDLE -> RUN -> DONE -> IDLE).
//               Optional feature macro: COIN_TRACKER_COUNT_EN enables the BCD
//               coin counter; without it coin_ones/coin_tens are constant 0.
// Ports       : Clk           - clock, rising edge
//               reset         - synchronous active-high reset
//               Start         - begin a run (IDLE only)
//               Stop          - end a run (RUN only), beats same-cycle events
//               Ack           - return to IDLE (DONE only)
//               get_zero      - bird overlaps slot 0
//               shift_coin    - rising edge advances the slots by one
//               show_coin     - per-slot visibility mask
//               coin_ones     - BCD ones digit of the count
//               coin_tens     - BCD tens digit of the count
//               collect_pulse - one-cycle strobe per collected coin
//               q_Idle/q_Run/q_Done - one-hot registered state flags
// Revision    : 1.0 - initial release
// ============================================================================
module coin_tracker
   import coin_tracker_pkg::*;
#(
   parameter int unsigned NUM_COINS = NUM_COINS_DEF,
   parameter int unsigned CNT_MAX   = CNT_MAX_DEF
) (
   input  logic                 Clk,
   input  logic                 reset,
   input  logic                 Start,
   input  logic                 Stop,
   input  logic                 Ack,
   input  logic                 get_zero,
   input  logic                 shift_coin,
   output logic [NUM_COINS-1:0] show_coin,
   output logic [3:0]           coin_ones,
   output logic [3:0]           coin_tens,
   output logic                 collect_pulse,
   output logic                 q_Idle,
   output logic                 q_Run,
   output logic                 q_Done
);

   localparam logic [NUM_COINS-1:0] C_ALL_ONES  = {NUM_COINS{1'b1}};
   localparam logic [NUM_COINS-1:0] C_CLR_SLOT0 = {{(NUM_COINS-1){1'b1}}, 1'b0};

   logic [2:0]           state_q, state_d;
   logic                 shift_prev_q, shift_prev_d;
   logic [NUM_COINS-1:0] show_coin_q, show_coin_d;
   logic                 collect_pulse_q, collect_pulse_d;

   logic                 run_active;
   logic                 shift_edge;
   logic                 collect;

   // Events only count in RUN when Stop is not ending the run this cycle.
   assign run_active = (state_q == ST_RUN) && !Stop;
   assign shift_edge = shift_coin && !shift_prev_q;
   assign collect    = run_active && get_zero && show_coin_q[0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (Start) state_d = ST_RUN;
         ST_RUN:  if (Stop)  state_d = ST_DONE;
         ST_DONE: if (Ack)   state_d = ST_IDLE;
         default:            state_d = ST_IDLE;
      endcase
   end

   // History register tracks shift_coin in every state so that a level
   // already high when the run starts is not seen as an edge.
   assign shift_prev_d = shift_coin;

   always_comb begin
      show_coin_d     = show_coin_q;
      collect_pulse_d = 1'b0;
      if (state_q == ST_IDLE) begin
         show_coin_d = C_ALL_ONES;
      end else if (run_active) begin
         // A shift moves the collected slot 0 out anyway, so on a combined
         // collect+shift the plain shift of the old mask is the result.
         if (shift_edge) begin
            show_coin_d = {1'b1, show_coin_q[NUM_COINS-1:1]};
         end else if (collect) begin
            show_coin_d = show_coin_q & C_CLR_SLOT0;
         end
         collect_pulse_d = collect;
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         shift_prev_q    <= 1'b0;
         show_coin_q     <= C_ALL_ONES;
         collect_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         shift_prev_q    <= shift_prev_d;
         show_coin_q     <= show_coin_d;
         collect_pulse_q <= collect_pulse_d;
      end
   end

   assign show_coin     = show_coin_q;
   assign collect_pulse = collect_pulse_q;
   assign q_Idle        = state_q[0];
   assign q_Run         = state_q[1];
   assign q_Done        = state_q[2];

`ifdef COIN_TRACKER_COUNT_EN
   logic count_clr;

   // Count is cleared on entering RUN so the previous total stays visible
   // through DONE and IDLE.
   assign count_clr = (state_q == ST_IDLE) && Start;

   bcd_sat_counter #(
      .CNT_MAX (CNT_MAX)
   ) u_bcd_sat_counter (
      .clk    (Clk),
      .rst    (reset),
      .i_clr  (count_clr),
      .i_en   (collect),
      .o_ones (coin_ones),
      .o_tens (coin_tens)
   );
`else
   logic unused_cnt_max;

   assign unused_cnt_max = |CNT_MAX;
   assign coin_ones      = 4'd0;
   assign coin_tens      = 4'd0;
`endif

endmodule : coin_tracker
`default_nettype wire

// File: tb/tb_coin_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_tracker
// Description : Directed self-checking bench for coin_tracker. Expected count
//               values follow COIN_TRACKER_COUNT_EN (0 when it is undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_tracker;

   logic       Clk = 1'b0;
   logic       reset = 1'b1;
   logic       Start = 1'b0;
   logic       Stop = 1'b0;
   logic       Ack = 1'b0;
   logic       get_zero = 1'b0;
   logic       shift_coin = 1'b0;
   logic [4:0] show_coin;
   logic [3:0] coin_ones;
   logic [3:0] coin_tens;
   logic       collect_pulse;
   logic       q_Idle, q_Run, q_Done;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;
   int exp_cnt = 0;

   coin_tracker #(
      .NUM_COINS (5),
      .CNT_MAX   (99)
   ) dut (
      .Clk           (Clk),
      .reset         (reset),
      .Start         (Start),
      .Stop          (Stop),
      .Ack           (Ack),
      .get_zero      (get_zero),
      .shift_coin    (shift_coin),
      .show_coin     (show_coin),
      .coin_ones     (coin_ones),
      .coin_tens     (coin_tens),
      .collect_pulse (collect_pulse),
      .q_Idle        (q_Idle),
      .q_Run         (q_Run),
      .q_Done        (q_Done)
   );

   always #5 Clk = ~Clk;

   function automatic logic [7:0] bcd(input int v);
      logic [7:0] r;
      r = {4'(v / 10), 4'(v % 10)};
`ifndef COIN_TRACKER_COUNT_EN
      r = 8'h00;
`endif
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; outputs settle 1 time unit after the edge; pulses tallied.
   task automatic tick();
      @(posedge Clk);
      #1;
      if (collect_pulse) pulses++;
   endtask

   function automatic logic [2:0] st();
      return {q_Done, q_Run, q_Idle};
   endfunction

   initial begin
      // Reset state
      tick(); tick();
      check("rst_state", 32'(st()), 32'b001);
      check("rst_mask", 32'(show_coin), 32'b11111);
      check("rst_count", 32'({coin_tens, coin_ones}), 32'h00);
      check("rst_pulse", 32'(collect_pulse), 32'd0);
      reset = 1'b0;

      // Stop/Ack ignored in IDLE
      Stop = 1'b1; Ack = 1'b1; tick();
      check("idle_hold", 32'(st()), 32'b001);
      Stop = 1'b0; Ack = 1'b0;

      // Start -> RUN
      Start = 1'b1; tick(); Start = 1'b0;
      check("start_run", 32'(st()), 32'b010);

      // get_zero held for 10 cycles collects exactly once
      pulses = 0;
      get_zero = 1'b1;
      tick();
      check("collect_pulse_lat1", 32'(collect_pulse), 32'd1);
      repeat (9) tick();
      get_zero = 1'b0;
      exp_cnt = 1;
      check("held_pulses", 32'(pulses), 32'd1);
      check("held_mask", 32'(show_coin), 32'b11110);
      check("held_count", 32'({coin_tens, coin_ones}), 32'(bcd(exp_cnt)));

      // Three separated shift edges
      pulses = 0;
      shift_coin = 1'b1; tick();
      check("shift1_mask", 32'(show_coin), 32'b11111);
      shift_coin = 1'b0; tick();
      repeat (2) begin
         shift_coin = 1'b1; tick();
         shift_coin = 1'b0; tick();
      end
      check("shift3_mask", 32'(show_coin), 32'b11111);
      check("shift_pulses", 32'(pulses), 32'd0);

      // Simultaneous collect and shift on mask 11111
      pulses = 0;
      get_zero = 1'b1; shift_coin = 1'b1; tick();
      get_zero = 1'b0; shift_coin = 1'b0;
      exp_cnt = 2;
      check("both_mask", 32'(show_coin), 32'b11111);
      check("both_pulse", 32'(collect_pulse), 32'd1);
      check("both_count", 32'({coin_tens, coin_ones}), 32'(bcd(exp_cnt)));
      tick();
      check("both_pulse_end", 32'(collect_pulse), 32'd0);

      // Climb to 98 with collect/shift pairs, checking the ones->tens wrap
      pulses = 0;
      for (int i = 0; i < 96; i++) begin
         get_zero = 1'b1; tick();
         get_zero = 1'b0; shift_coin = 1'b1; tick();
         shift_coin = 1'b0; tick();
         exp_cnt++;
         if (exp_cnt == 10) check("wrap_10", 32'({coin_tens, coin_ones}), 32'(bcd(10)));
      end
      check("climb_pulses", 32'(pulses), 32'd96);
      check("count_98", 32'({coin_tens, coin_ones}), 32'(bcd(98)));

      // Saturation
      get_zero = 1'b1; tick(); get_zero = 1'b0;
      check("count_99", 32'({coin_tens, coin_ones}), 32'(bcd(99)));
      shift_coin = 1'b1; tick(); shift_coin = 1'b0; tick();
      get_zero = 1'b1; tick(); get_zero = 1'b0;
      check("sat_pulse", 32'(collect_pulse), 32'd1);
      check("sat_count", 32'({coin_tens, coin_ones}), 32'(bcd(99)));
      check("sat_mask", 32'(show_coin), 32'b11110);
      shift_coin = 1'b1; tick(); shift_coin = 1'b0; tick();

      // Stop beats same-cycle collect
      pulses = 0;
      Stop = 1'b1; get_zero = 1'b1; tick();
      Stop = 1'b0;
      check("stop_state", 32'(st()), 32'b100);
      check("stop_mask", 32'(show_coin), 32'b11111);
      check("stop_count", 32'({coin_tens, coin_ones}), 32'(bcd(99)));
      // DONE freezes the mask even with get_zero and shift edges
      shift_coin = 1'b1; tick(); shift_coin = 1'b0; tick();
      get_zero = 1'b0;
      check("done_mask", 32'(show_coin), 32'b11111);
      check("done_pulses", 32'(pulses), 32'd0);
      Ack = 1'b1; tick(); Ack = 1'b0;
      check("ack_idle", 32'(st()), 32'b001);
      check("idle_keeps_count", 32'({coin_tens, coin_ones}), 32'(bcd(99)));
      Start = 1'b1; tick(); Start = 1'b0;
      check("restart_state", 32'(st()), 32'b010);
      check("restart_count", 32'({coin_tens, coin_ones}), 32'(bcd(0)));

      // Mid-run reset wins over a same-cycle collect
      get_zero = 1'b1; tick(); get_zero = 1'b0;
      check("pre_rst_count", 32'({coin_tens, coin_ones}), 32'(bcd(1)));
      get_zero = 1'b1; shift_coin = 1'b1; reset = 1'b1; tick();
      get_zero = 1'b0; reset = 1'b0;
      check("midrst_state", 32'(st()), 32'b001);
      check("midrst_mask", 32'(show_coin), 32'b11111);
      check("midrst_count", 32'({coin_tens, coin_ones}), 32'h00);
      check("midrst_pulse", 32'(collect_pulse), 32'd0);

      // shift_coin already high on entry to RUN is not an edge
      tick();
      Start = 1'b1; tick(); Start = 1'b0;
      get_zero = 1'b1; tick(); get_zero = 1'b0;
      check("entry_no_shift", 32'(show_coin), 32'b11110);
      tick();
      check("held_shift_no_edge", 32'(show_coin), 32'b11110);
      shift_coin = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_coin_tracker
`default_nettype wire
